bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD digits per input word, minimum 1.
REQ-002 Parameter BIN_W, default 14: binary result width; SHALL satisfy 10^DIGITS-1 < 2^BIN_W (14 for 4 digits).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_bcd holds a word to convert.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_bcd  input  4*DIGITS  packed BCD; most significant digit in bits [4*DIGITS-1:4*DIGITS-4].
REQ-008 out_valid  output  1  out_bin holds a completed result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_bin  output  BIN_W  binary value of the accepted word.
REQ-011 err  output  1  invalid-digit flag; present only under BCD2BIN_SEQ_CHECK_EN.

Function
REQ-012 FSM states: IDLE, CONV, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; in_valid in any other state is ignored and the word is not captured.
REQ-014 Accept in IDLE (in_valid & in_ready, cycle T): latch in_bcd, clear accumulator, set digit counter to DIGITS-1, go to CONV.
REQ-015 CONV, each cycle: acc <= acc*10 + digit[cnt], acc*10 formed as (acc<<3)+(acc<<1), truncated to BIN_W; cnt decrements.
REQ-016 CONV processes the MSD first; after the cycle with cnt==0, go to DONE.
REQ-017 Latency is fixed: with DIGITS=4, CONV spans T+1..T+4 and out_valid rises at T+5, independent of data value.
REQ-018 In DONE, out_valid=1, and out_bin (and err) SHALL stay stable until out_valid & out_ready.
REQ-019 The out_valid & out_ready handshake returns the FSM to IDLE next cycle, where out_valid=0; minimum throughput is one word per DIGITS+2 cycles.
REQ-020 out_bin SHALL hold the last result while in IDLE and CONV; only out_valid qualifies it.
REQ-021 Digit values 10..15 SHALL be processed arithmetically (acc*10+d), with no saturation.

Reset
REQ-022 rst in any state SHALL force IDLE next edge, with out_valid=0, out_bin=0, err=0, acc=0, cnt=0 and in_ready=1 in the cycle after rst deasserts.
REQ-023 A transaction in CONV or DONE when rst is asserted SHALL be dropped, and no out_valid is produced for it.
REQ-024 rst has priority over every concurrent handshake.

Configuration
REQ-025 Macro BCD2BIN_SEQ_CHECK_EN, when defined: err port exists and is cleared on accept; err is set if any CONV digit exceeds 9 and stays set until the next accept or rst.
REQ-026 Without BCD2BIN_SEQ_CHECK_EN: no err port and no check logic; out_bin is identical in both builds.

Structure
REQ-027 Package bcd_pkg SHALL hold the FSM state encoding typedef, the BCD digit width constant (4) and the max-valid-digit constant (9).
REQ-028 A single sub-module mul10_add (inputs acc [BIN_W], digit [4]; output acc*10+digit [BIN_W]) SHALL implement the combinational step, built from shifts and adders.
REQ-029 There SHALL be no other sub-module.

Verification
REQ-030 in_bcd=16'h1234 accepted at T, out_ready=1 -> out_valid=1 at T+5 with out_bin=1234, and IDLE (in_ready=1) at T+6.
REQ-031 16'h9999 -> 9999; 16'h0000 -> 0, each with the same T+5 latency.
REQ-032 out_ready held 0 for 3 cycles after out_valid -> out_bin stable and in_ready=0 throughout; release -> one handshake, then IDLE.
REQ-033 in_valid with 16'h5555 asserted during CONV of 16'h0042 -> result 42 only, and 16'h5555 is not captured.
REQ-034 rst pulsed at T+2 mid-CONV -> no out_valid, out_bin=0, and in_ready=1 after rst deasserts; the next word 16'h0007 -> 7.
REQ-035 With BCD2BIN_SEQ_CHECK_EN defined, 16'h12A4 -> out_bin=1304 and err=1; the next word 16'h0001 -> err=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential BCD-to-binary converter.
package bcd_pkg;
    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/bcd2bin_seq_mul10_add.sv
// One conversion step: result = acc*10 + digit, truncated to BIN_W, using shifts and adders only.
module mul10_add
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [BIN_W-1:0]   result
);
    // acc*10 = acc*8 + acc*2
    assign result = (acc << 3) + (acc << 1) + BIN_W'(digit);
endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Optional invalid-digit flag (err port) enabled by defining BCD2BIN_SEQ_CHECK_EN.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef BCD2BIN_SEQ_CHECK_EN
    output logic                      err,
`endif
    output logic [BIN_W-1:0]          out_bin
);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                      state_q, state_d;
    logic [DIGIT_W*DIGITS-1:0]   bcd_q;
    logic [BIN_W-1:0]            acc_q;
    logic [BIN_W-1:0]            acc_nxt;
    logic [BIN_W-1:0]            res_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [DIGIT_W-1:0]          digit;
    logic                        accept;
    logic                        last_digit;

    assign digit      = bcd_q[DIGIT_W*int'(cnt_q) +: DIGIT_W];
    assign accept     = (state_q == IDLE) && in_valid;
    assign last_digit = (cnt_q == '0);
    assign out_bin    = res_q;

    mul10_add #(.BIN_W(BIN_W)) u_step (
        .acc    (acc_q),
        .digit  (digit),
        .result (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CONV;
            end
            CONV: if (last_digit) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result register is separate from the accumulator so out_bin keeps the
    // previous answer while the next word is being converted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    bcd_q <= in_bcd;
                    acc_q <= '0;
                    cnt_q <= CNT_W'(DIGITS-1);
                end
                CONV: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last_digit) res_q <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef BCD2BIN_SEQ_CHECK_EN
    logic err_q;
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if (state_q == CONV && digit > DIGIT_W'(MAX_DIGIT))
            err_q <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed cases plus random words against a decimal-weight model.
module tb_bcd2bin_seq;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [4*DIGITS-1:0] in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  out_bin;
`ifdef BCD2BIN_SEQ_CHECK_EN
    logic              err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int prev_res = 0;

    always #5 clk = ~clk;

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BCD2BIN_SEQ_CHECK_EN
        .err       (err),
`endif
        .out_bin   (out_bin)
    );

    // Value = sum of digit_i * 10^i, reduced modulo 2^BIN_W (digits above 9 included as-is).
    function automatic int ref_bin(input logic [4*DIGITS-1:0] w);
        int v = 0;
        int pw = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v += int'(w[4*i +: 4]) * pw;
            pw *= 10;
        end
        return v % (1 << BIN_W);
    endfunction

    function automatic logic ref_err(input logic [4*DIGITS-1:0] w);
        for (int i = 0; i < DIGITS; i++)
            if (w[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_bin", 32'(out_bin), 0);
`ifdef BCD2BIN_SEQ_CHECK_EN
        chk("rst_err", 32'(err), 0);
`endif
        prev_res = 0;
    endtask

    // Full transaction starting in IDLE; noise drives random in_valid/in_bcd while busy.
    task automatic xact(input logic [4*DIGITS-1:0] w, input int hold, input bit noise);
        int exp = ref_bin(w);
        chk("accept_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_bcd   = w;
        cyc();                              // now in T+1
        in_valid = 1'b0;
        for (int k = 1; k <= DIGITS; k++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_bcd   = 16'h5555;
            end
            chk("conv_out_valid", 32'(out_valid), 0);
            chk("conv_in_ready", 32'(in_ready), 0);
            chk("conv_hold_bin", 32'(out_bin), 32'(prev_res));
            cyc();
        end
        // T+5: result must be presented now, regardless of data
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_bin", 32'(out_bin), 32'(exp));
            chk("stall_in_ready", 32'(in_ready), 0);
            cyc();
        end
        out_ready = 1'b1;
        chk("done_out_valid", 32'(out_valid), 1);
        chk("done_out_bin", 32'(out_bin), 32'(exp));
`ifdef BCD2BIN_SEQ_CHECK_EN
        chk("done_err", 32'(err), 32'(ref_err(w)));
`endif
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_hold_bin", 32'(out_bin), 32'(exp));
        prev_res = exp;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bcd    = '0;
        cyc();
        do_reset();

        xact(16'h1234, 0, 1'b0);
        xact(16'h9999, 0, 1'b0);
        xact(16'h0000, 0, 1'b0);
        xact(16'h0042, 0, 1'b1);
        xact(16'h0815, 3, 1'b0);
        xact(16'h12A4, 0, 1'b0);
        xact(16'h0001, 0, 1'b0);
        xact(16'hFFFF, 1, 1'b1);

        // Reset mid-conversion drops the word
        chk("pre_mid_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_bcd   = 16'h4321;
        cyc();
        in_valid = 1'b0;
        cyc();
        do_reset();
        for (int k = 0; k < DIGITS + 2; k++) begin
            chk("dropped_out_valid", 32'(out_valid), 0);
            cyc();
        end
        xact(16'h0007, 0, 1'b0);

        // Reset while result is presented, with a concurrent handshake
        in_valid = 1'b1;
        in_bcd   = 16'h0555;
        cyc();
        in_valid = 1'b0;
        repeat (DIGITS) cyc();
        chk("pre_rst_done_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc();
        chk("post_rst_idle_valid", 32'(out_valid), 0);

        for (int n = 0; n < 24; n++) begin
            logic [4*DIGITS-1:0] w;
            for (int d = 0; d < DIGITS; d++)
                w[4*d +: 4] = (n % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            xact(w, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
